// File: rtl/binary_game_pkg.sv
// binary_game_pkg
//   Shared definitions for the binary-matching game round controller:
//   - state_t      : round controller states
//   - lfsr_taps()  : feedback tap mask of a maximal-length Fibonacci LFSR
//                    for widths 4..16 (bit i set = stage i+1 feeds back)
//   - cnt_w()      : register width able to hold 0..n-1, never below 1
package binary_game_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    HIT  = 3'd3,
    MISS = 3'd4,
    DONE = 3'd5
  } state_t;

  // Primitive polynomials: the mask lists the exponents of the polynomial
  // (minus one) apart from the constant term.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] mask;
    case (width)
      4:       mask = 16'h000C;  // x^4+x^3+1
      5:       mask = 16'h0014;  // x^5+x^3+1
      6:       mask = 16'h0030;  // x^6+x^5+1
      7:       mask = 16'h0060;  // x^7+x^6+1
      8:       mask = 16'h00B8;  // x^8+x^6+x^5+x^4+1
      9:       mask = 16'h0110;  // x^9+x^5+1
      10:      mask = 16'h0240;  // x^10+x^7+1
      11:      mask = 16'h0500;  // x^11+x^9+1
      12:      mask = 16'h0829;  // x^12+x^6+x^4+x+1
      13:      mask = 16'h100D;  // x^13+x^4+x^3+x+1
      14:      mask = 16'h2015;  // x^14+x^5+x^3+x+1
      15:      mask = 16'h6000;  // x^15+x^14+1
      16:      mask = 16'hD008;  // x^16+x^15+x^13+x^4+1
      default: mask = 16'h00B8;
    endcase
    return mask;
  endfunction

  // Width of a counter that must represent values 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/binary_game_core_lfsr_gen.sv
// lfsr_gen
//   Free-running maximal-length Fibonacci LFSR used as the target source.
//   Advances on every clk while rst is low; period is 2^WIDTH-1.
//   Ports:
//     clk   in          system clock
//     rst   in          asynchronous active-high reset, loads SEED
//     value out [WIDTH] current LFSR state
module lfsr_gen
  import binary_game_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int unsigned SEED  = 'hA5
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] value
);

  localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT      = WIDTH'(SEED);

  // Per-stage tap contribution; the feedback is their parity.
  logic [WIDTH-1:0] tapped;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign tapped[gi] = value[gi] & TAPS[gi];
    end
  endgenerate

  logic feedback;
  assign feedback = ^tapped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= INIT;
    end else begin
      value <= {value[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/binary_game_core.sv
// binary_game_core
//   Round controller for the binary-matching game. Each round loads a
//   target from the LFSR, then counts down TIME_LIMIT ticks while the
//   player tries to hold sw == target for HOLD consecutive ticks.
//   Hits and misses are tallied over ROUNDS rounds.
//   Ports:
//     clk        in           system clock
//     rst        in           asynchronous active-high reset
//     tick_en    in           one-clk time-base pulse (used only in PLAY)
//     start      in           starts a game from IDLE or DONE
//     sw         in  [WIDTH]  player switches
//     target     out [WIDTH]  current target
//     score      out          hits this game
//     round_idx  out          current round, 0-based
//     time_left  out          ticks remaining in the round
//     playing    out          high in PLAY
//     hit        out          one-clk pulse on a successful round
//     miss       out          one-clk pulse on a timed-out round
//     game_over  out          high in DONE
//   All outputs are registered.
module binary_game_core
  import binary_game_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int          ROUNDS     = 10,
  parameter int          TIME_LIMIT = 30,
  parameter int          HOLD       = 2,
  parameter int unsigned SEED       = 'hA5,
  localparam int         SCW        = cnt_w(ROUNDS + 1),
  localparam int         RW         = cnt_w(ROUNDS),
  localparam int         TW         = cnt_w(TIME_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             start,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] target,
  output logic [SCW-1:0]   score,
  output logic [RW-1:0]    round_idx,
  output logic [TW-1:0]    time_left,
  output logic             playing,
  output logic             hit,
  output logic             miss,
  output logic             game_over
);

  localparam int HW = cnt_w(HOLD);

  state_t           state, state_next;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] target_next;
  logic [SCW-1:0]   score_next;
  logic [RW-1:0]    round_next;
  logic [TW-1:0]    time_next;
  logic [HW-1:0]    hold_cnt, hold_next;

  lfsr_gen #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  logic match;
  logic hold_done;
  logic last_round;

  assign match      = (sw == target);
  assign hold_done  = match && (hold_cnt == HW'(HOLD - 1));
  assign last_round = (round_idx == RW'(ROUNDS - 1));

  always_comb begin
    state_next  = state;
    target_next = target;
    score_next  = score;
    round_next  = round_idx;
    time_next   = time_left;
    hold_next   = hold_cnt;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = LOAD;
          score_next = '0;
          round_next = '0;
        end
      end

      LOAD: begin
        time_next  = TW'(TIME_LIMIT);
        hold_next  = '0;
        // Never hand out a target the switches already show.
        target_next = (lfsr != sw) ? lfsr : ~lfsr;
        state_next  = PLAY;
      end

      PLAY: begin
        // Any mismatching clk breaks the hold streak, tick or not.
        if (!match) begin
          hold_next = '0;
        end
        if (tick_en) begin
          time_next = time_left - TW'(1);
          // Hold completion is checked first so that it wins over a
          // timeout landing on the same tick.
          if (hold_done) begin
            state_next = HIT;
            score_next = score + SCW'(1);
          end else begin
            if (match) begin
              hold_next = hold_cnt + HW'(1);
            end
            if (time_left == TW'(1)) begin
              state_next = MISS;
            end
          end
        end
      end

      HIT, MISS: begin
        if (last_round) begin
          state_next = DONE;
        end else begin
          round_next = round_idx + RW'(1);
          state_next = LOAD;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      score     <= '0;
      round_idx <= '0;
      time_left <= '0;
      hold_cnt  <= '0;
      playing   <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_next;
      target    <= target_next;
      score     <= score_next;
      round_idx <= round_next;
      time_left <= time_next;
      hold_cnt  <= hold_next;
      // Status flags follow the state being entered so they line up
      // with the state register rather than lagging it.
      playing   <= (state_next == PLAY);
      hit       <= (state_next == HIT);
      miss      <= (state_next == MISS);
      game_over <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_binary_game_core.sv
module tb_binary_game_core;

  localparam int W    = 8;
  localparam int R    = 3;
  localparam int TL   = 30;
  localparam int HOLD = 2;
  localparam int SCW  = $clog2(R + 1);
  localparam int RW   = $clog2(R);
  localparam int TW   = $clog2(TL + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rst_aux = 1'b1;
  logic         tick_en = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] sw = '0;

  logic [W-1:0]   target;
  logic [SCW-1:0] score;
  logic [RW-1:0]  round_idx;
  logic [TW-1:0]  time_left;
  logic           playing, hit, miss, game_over;

  always #5 clk = ~clk;

  binary_game_core #(
    .WIDTH(W), .ROUNDS(R), .TIME_LIMIT(TL), .HOLD(HOLD), .SEED('hA5)
  ) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .start(start), .sw(sw),
    .target(target), .score(score), .round_idx(round_idx),
    .time_left(time_left), .playing(playing), .hit(hit), .miss(miss),
    .game_over(game_over)
  );

  // Idle instances used only to measure the LFSR period at the width extremes.
  logic [3:0]  t4;
  logic [15:0] t16;
  logic [3:0]  sc4, sc16, ri4, ri16;
  logic [4:0]  tl4, tl16;
  logic        pl4, h4, m4, go4, pl16, h16, m16, go16;

  binary_game_core #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst_aux), .tick_en(1'b0), .start(1'b0), .sw(4'h0),
    .target(t4), .score(sc4), .round_idx(ri4), .time_left(tl4),
    .playing(pl4), .hit(h4), .miss(m4), .game_over(go4)
  );

  binary_game_core #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst_aux), .tick_en(1'b0), .start(1'b0), .sw(16'h0),
    .target(t16), .score(sc16), .round_idx(ri16), .time_left(tl16),
    .playing(pl16), .hit(h16), .miss(m16), .game_over(go16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference random source: x^8+x^6+x^5+x^4+1 Fibonacci sequence from
  // seed A5, one step per clk out of reset.
  logic [W-1:0] m_lfsr;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  int           exp_score;
  logic [W-1:0] exp_target;

  // Called in the LOAD cycle; returns in the cycle after the round's
  // hit/miss pulse (next LOAD, or DONE for the last round).
  task automatic play_round(input int r, input int mode, input bit force_eq);
    int  ticks, run, outcome, n;
    bit  tk, mt, glitched;
    logic [W-1:0] lf;

    lf = m_lfsr;
    sw = force_eq ? lf : W'($urandom);
    exp_target = (sw != lf) ? lf : ~lf;
    tick_en = 1'($urandom);
    start   = 1'($urandom);
    step();
    check_val("target_load", target, exp_target);
    check_val("time_left_load", time_left, TL);
    check_val("playing_load", playing, 1);
    check_val("round_idx_play", round_idx, r);

    ticks = 0; run = 0; outcome = 0; n = 0; glitched = 0;
    while (outcome == 0) begin
      case (mode)
        1:       mt = 1'b0;
        2:       mt = 1'b1;
        3:       mt = (ticks >= TL - HOLD);
        4:       mt = 1'b1;
        default: mt = ($urandom_range(0, 4) != 0);
      endcase
      tk = (n >= 300) ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (mode == 4 && ticks == 1 && !glitched) begin
        mt = 1'b0; tk = 1'b0; glitched = 1'b1;
      end
      sw      = mt ? exp_target : exp_target ^ W'($urandom_range(1, 255));
      tick_en = tk;
      start   = 1'($urandom);

      // Round rules: hold completes on a matching tick after HOLD-1 prior
      // unbroken matching ticks; otherwise every tick uses up time.
      if (tk && mt && run == HOLD - 1) outcome = 1;
      else if (tk) begin
        ticks++;
        if (ticks == TL) outcome = 2;
      end
      if (!mt) run = 0;
      else if (tk) run++;
      if (outcome == 1) exp_score++;

      step();
      n++;
      if (outcome == 1) begin
        check_val("hit_pulse", hit, 1);
        check_val("miss_on_hit", miss, 0);
        check_val("score_hit", score, exp_score);
      end else if (outcome == 2) begin
        check_val("miss_pulse", miss, 1);
        check_val("hit_on_miss", hit, 0);
        check_val("score_miss", score, exp_score);
      end else begin
        check_val("no_pulse", {hit, miss}, 0);
        check_val("playing", playing, 1);
        check_val("time_left", time_left, TL - ticks);
      end
    end

    sw = W'($urandom); tick_en = 1'($urandom); start = 1'($urandom);
    step();
    start = 1'b0;
    check_val("pulse_clear", {hit, miss, playing}, 0);
    check_val("game_over_next", game_over, (r == R - 1));
    check_val("round_idx_next", round_idx, (r == R - 1) ? r : r + 1);
    $display("round %0d mode %0d target=%0h outcome=%s clks=%0d score=%0d",
             r, mode, exp_target, (outcome == 1) ? "hit" : "miss", n, exp_score);
  endtask

  task automatic play_game(input int m0, input int m1, input int m2,
                           input bit f0);
    int modes[3];
    modes[0] = m0; modes[1] = m1; modes[2] = m2;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_score = 0;
    check_val("score_cleared", score, 0);
    check_val("round_cleared", round_idx, 0);
    check_val("game_over_cleared", game_over, 0);
    for (int r = 0; r < R; r++) begin
      play_round(r, modes[r], (r == 0) ? f0 : ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 4; i++) begin
      tick_en = 1'($urandom); sw = W'($urandom);
      step();
      check_val("done_game_over", game_over, 1);
      check_val("done_score", score, exp_score);
      check_val("done_target", target, exp_target);
    end
    $display("game modes %0d/%0d/%0d final score=%0d", m0, m1, m2, exp_score);
  endtask

  int p4 = 0, p16 = 0;
  bit lfsr_zero = 0, per_done = 0;

  initial begin
    logic [3:0]  v4;
    logic [15:0] v16;
    wait (!rst_aux);
    v4  = dut4.u_lfsr.value;
    v16 = dut16.u_lfsr.value;
    for (int n = 1; n <= 70000; n++) begin
      @(posedge clk);
      #1;
      if (dut16.u_lfsr.value == 16'h0 || dut4.u_lfsr.value == 4'h0) lfsr_zero = 1;
      if (p4 == 0 && dut4.u_lfsr.value == v4) p4 = n;
      if (dut16.u_lfsr.value == v16) begin
        p16 = n;
        break;
      end
    end
    per_done = 1;
  end

  initial begin
    #1;
    check_val("rst_target", target, 0);
    check_val("rst_status", {playing, hit, miss, game_over}, 0);
    repeat (2) step();
    rst = 1'b0;
    rst_aux = 1'b0;
    check_val("rst_score", score, 0);
    check_val("rst_round", round_idx, 0);
    check_val("rst_time", time_left, 0);
    for (int i = 0; i < 3; i++) begin
      tick_en = 1'($urandom); sw = W'($urandom);
      step();
      check_val("idle_stays", {playing, game_over}, 0);
    end

    // Directed: hit, miss, hit with a forced equal load; then boundary,
    // glitch and random.
    play_game(2, 1, 2, 1'b1);
    play_game(3, 4, 0, 1'b0);

    // Reset in the middle of a round.
    start = 1'b1; step(); start = 1'b0;
    sw = W'($urandom); step();
    for (int i = 0; i < 5; i++) begin
      tick_en = 1'($urandom); sw = target;
      step();
    end
    #2 rst = 1'b1;
    #1;
    check_val("midrst_target", target, 0);
    check_val("midrst_score", score, 0);
    check_val("midrst_time", time_left, 0);
    check_val("midrst_status", {playing, hit, miss, game_over}, 0);
    step();
    rst = 1'b0;
    check_val("midrst_round", round_idx, 0);
    $display("mid-round reset done");

    for (int g = 0; g < 4; g++) begin
      play_game($urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), 1'($urandom));
    end

    tick_en = 1'b0;
    while (!per_done) step();
    check_val("lfsr_period_w4", p4, 15);
    check_val("lfsr_period_w16", p16, 65535);
    check_val("lfsr_never_zero", lfsr_zero, 0);
    $display("lfsr periods w4=%0d w16=%0d", p4, p16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
